alu_seq: RTL

Parametrised sequential ALU with a valid/ready input handshake, flag outputs and a multi-cycle restoring divider that returns both quotient and remainder. It sits between the register file / control FSM and the datapath writeback, as the next-generation arithmetic unit of the system. Single-cycle operations complete in one clock. Division runs one quotient bit per clock and stalls the input side while it runs.

---
 rtl/alu_seq_if.sv | 31 +++
 rtl/alu_seq.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/opcode request and result bundle for alu_seq.
//   master: drives IN_VALID, A, B, ALU_FUN; observes IN_READY and results.
//   slave : the ALU; drives IN_READY, ALU_OUT, OUT_VALID and the flags.
// Handshake: an operation transfers on a rising edge where IN_VALID && IN_READY.
// While IN_READY is low the master keeps IN_VALID/A/B/ALU_FUN stable. Results
// have no backpressure: ALU_OUT and the flags must be sampled while OUT_VALID is high.
interface alu_seq_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FUNC_WIDTH = 4
);
  logic                      IN_VALID;
  logic                      IN_READY;
  logic [DATA_WIDTH-1:0]     A;
  logic [DATA_WIDTH-1:0]     B;
  logic [FUNC_WIDTH-1:0]     ALU_FUN;
  logic [2*DATA_WIDTH-1:0]   ALU_OUT;
  logic                      OUT_VALID;
  logic                      ZERO_FLAG;
  logic                      CARRY_FLAG;
  logic                      DIV0_FLAG;

  modport master (
    output IN_VALID, A, B, ALU_FUN,
    input  IN_READY, ALU_OUT, OUT_VALID, ZERO_FLAG, CARRY_FLAG, DIV0_FLAG
  );

  modport slave (
    input  IN_VALID, A, B, ALU_FUN,
    output IN_READY, ALU_OUT, OUT_VALID, ZERO_FLAG, CARRY_FLAG, DIV0_FLAG
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU. Single-cycle ops register their result on the
// accept edge; DIV with a non-zero divisor runs a restoring divider, one
// quotient bit per clock, holding IN_READY low until it finishes.
// Ports:
//   CLK          rising-edge clock
//   RST          asynchronous active-low reset
//   bus          alu_seq_if slave (request in, registered result + flags out)
//   dbg_state_o  1 while the divider is running (FSM state DIV)
module alu_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int FUNC_WIDTH = 4
) (
  input  logic       CLK,
  input  logic       RST,
  alu_seq_if.slave   bus,
  output logic       dbg_state_o
);
  localparam int W  = DATA_WIDTH;
  localparam int RW = 2 * DATA_WIDTH;
  localparam int SW = $clog2(DATA_WIDTH);

  typedef enum logic {S_IDLE = 1'b0, S_DIV = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    dvd_q, dvd_d;   // dividend shifting out, quotient shifting in
  logic [W-1:0]    dvs_q, dvs_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [RW-1:0]   out_q, out_d;
  logic            vld_q, vld_d;
  logic            zero_q, zero_d;
  logic            carry_q, carry_d;
  logic            div0_q, div0_d;

  logic [3:0]      op;
  assign op = bus.ALU_FUN[3:0];

  // Single-cycle result. Narrow results are built in a W-bit temporary so that
  // inversion/subtraction never leaks ones into the upper half.
  logic [RW-1:0]   op_res;
  logic            op_carry;
  logic [W:0]      sum;
  logic [W-1:0]    lo;
  logic            use_lo;
  logic [SW-1:0]   sh;

  always_comb begin
    op_res   = '0;
    op_carry = 1'b0;
    lo       = '0;
    use_lo   = 1'b0;
    sum      = {1'b0, bus.A} + {1'b0, bus.B};
    sh       = bus.B[SW-1:0];
    case (op)
      4'd0:  begin op_res = RW'(sum); op_carry = sum[W]; end
      4'd1:  begin lo = bus.A - bus.B; use_lo = 1'b1; op_carry = (bus.A < bus.B); end
      4'd2:  op_res = RW'(bus.A) * RW'(bus.B);
      4'd4:  begin lo = bus.A & bus.B;    use_lo = 1'b1; end
      4'd5:  begin lo = bus.A | bus.B;    use_lo = 1'b1; end
      4'd6:  begin lo = ~(bus.A & bus.B); use_lo = 1'b1; end
      4'd7:  begin lo = ~(bus.A | bus.B); use_lo = 1'b1; end
      4'd8:  begin lo = bus.A ^ bus.B;    use_lo = 1'b1; end
      4'd9:  begin lo = ~(bus.A ^ bus.B); use_lo = 1'b1; end
      4'd10: op_res = (bus.A == bus.B) ? RW'(1) : '0;
      4'd11: op_res = (bus.A >  bus.B) ? RW'(2) : '0;
      4'd12: op_res = (bus.A <  bus.B) ? RW'(3) : '0;
      4'd13: begin lo = bus.A >> sh; use_lo = 1'b1; end
      4'd14: op_res = RW'(bus.A) << sh;
      default: op_res = '0;  // DIV (only reaches here when B==0) and reserved
    endcase
    if (use_lo) op_res = {{W{1'b0}}, lo};
  end

  // One restoring step. The shifted remainder needs W+1 bits because it can
  // reach 2*B-1 before the trial subtraction.
  logic [W:0]      rem_sh, rem_sub;
  logic            q_bit;
  logic [W-1:0]    rem_nx, dvd_nx;

  always_comb begin
    rem_sh  = {rem_q, dvd_q[W-1]};
    rem_sub = rem_sh - {1'b0, dvs_q};
    q_bit   = (rem_sh >= {1'b0, dvs_q});
    rem_nx  = q_bit ? rem_sub[W-1:0] : rem_sh[W-1:0];
    dvd_nx  = {dvd_q[W-2:0], q_bit};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    out_d   = out_q;
    vld_d   = 1'b0;
    zero_d  = zero_q;
    carry_d = carry_q;
    div0_d  = div0_q;
    case (state_q)
      S_IDLE: begin
        if (bus.IN_VALID) begin
          if (op == 4'd3 && bus.B != '0) begin
            dvd_d   = bus.A;
            dvs_d   = bus.B;
            rem_d   = '0;
            cnt_d   = SW'(W - 1);
            state_d = S_DIV;
          end else begin
            out_d   = op_res;
            vld_d   = 1'b1;
            zero_d  = (op_res == '0);
            carry_d = op_carry;
            div0_d  = (op == 4'd3);
          end
        end
      end
      S_DIV: begin
        rem_d = rem_nx;
        dvd_d = dvd_nx;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          out_d   = {rem_nx, dvd_nx};
          vld_d   = 1'b1;
          zero_d  = ({rem_nx, dvd_nx} == '0);
          carry_d = 1'b0;
          div0_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      div0_q  <= div0_d;
    end
  end

  assign bus.IN_READY   = (state_q == S_IDLE);
  assign bus.ALU_OUT    = out_q;
  assign bus.OUT_VALID  = vld_q;
  assign bus.ZERO_FLAG  = zero_q;
  assign bus.CARRY_FLAG = carry_q;
  assign bus.DIV0_FLAG  = div0_q;
  assign dbg_state_o    = (state_q == S_DIV);
endmodule
